// File: rtl/lfsr_sequence_checker.sv
// Drives an 8-bit LFSR through one reseed and burst, captures the burst into a small buffer,
// then scores in-order player guesses against the captured words.
module lfsr_sequence_checker #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   lfsr_out,
    input  logic               lfsr_complete,
    output logic               lfsr_rst,
    output logic               lfsr_enable,
    input  logic               guess_valid,
    input  logic [WIDTH-1:0]   guess_data,
    output logic               guess_ready,
    output logic               match_pulse,
    output logic               mismatch_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_CAPTURE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               err_q, err_d;
    logic               match_q, match_d;
    logic               mismatch_q, mismatch_d;
    logic               wr_en;
    logic [WIDTH-1:0]   buf_q [DEPTH];
    logic [WIDTH-1:0]   rd_data;

    assign rd_data = buf_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        score_d    = score_q;
        err_d      = err_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SEED;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    score_d  = '0;
                    err_d    = 1'b0;
                end
            end
            S_SEED: state_d = S_CAPTURE;
            S_CAPTURE: begin
                // An all-zero word means a zero seed: the LFSR would never finish its burst.
                if (lfsr_out == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                    if (lfsr_complete || (count_q == CNT_W'(DEPTH - 1))) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (guess_valid) begin
                    if (guess_data == rd_data) begin
                        match_d  = 1'b1;
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        if ((CNT_W'(rd_ptr_q) + CNT_W'(1)) == count_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            score_q    <= '0;
            err_q      <= 1'b0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            score_q    <= score_d;
            err_q      <= err_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Capture buffer: contents are don't-care after reset, so no reset term.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
                buf_q[gi] <= lfsr_out;
            end
        end
    end

    assign lfsr_rst       = (state_q == S_SEED);
    assign lfsr_enable    = (state_q == S_CAPTURE);
    assign guess_ready    = (state_q == S_CHECK);
    assign busy           = (state_q == S_SEED) || (state_q == S_CAPTURE) || (state_q == S_CHECK);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign score          = score_q;
    assign match_pulse    = match_q;
    assign mismatch_pulse = mismatch_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Scoreboard bench: a behavioural LFSR feeds the checker, a reference model predicts each guess
// outcome into a queue, and a negedge monitor pops and compares on every match/mismatch pulse.
module tb_lfsr_sequence_checker;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int SCORE_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   lfsr_out = '0;
    logic               lfsr_complete;
    logic               lfsr_rst;
    logic               lfsr_enable;
    logic               guess_valid;
    logic [WIDTH-1:0]   guess_data;
    logic               guess_ready;
    logic               match_pulse;
    logic               mismatch_pulse;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               done;
    logic               err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] cur_seed  = 8'h01;
    int         cur_burst = 8;
    int         lfsr_steps = 0;

    logic [7:0] exp_w [DEPTH];
    logic [7:0] g_q [$];
    logic [6:0] exp_q [$];   // {match, mismatch, score, done}
    logic [6:0] mon_e;

    lfsr_sequence_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .lfsr_out(lfsr_out), .lfsr_complete(lfsr_complete),
        .lfsr_rst(lfsr_rst), .lfsr_enable(lfsr_enable),
        .guess_valid(guess_valid), .guess_data(guess_data), .guess_ready(guess_ready),
        .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
        .score(score), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Fibonacci LFSR, taps 7,5,4,3: 01 -> 02 -> 04 -> 08 -> 11 -> 23 -> 47 -> 8E
    function automatic logic [7:0] lfsr_next(input logic [7:0] w);
        return {w[6:0], ^(w & 8'hB8)};
    endfunction

    always @(posedge clk) begin
        if (lfsr_rst) begin
            lfsr_out   <= cur_seed;
            lfsr_steps <= 0;
        end else if (lfsr_enable) begin
            lfsr_out   <= lfsr_next(lfsr_out);
            lfsr_steps <= lfsr_steps + 1;
        end
    end
    assign lfsr_complete = (lfsr_steps == cur_burst - 1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Words the checker should capture: the seed and its successors, up to burst or buffer size.
    task automatic gen_words(input logic [7:0] seed, input int burst, output int n);
        logic [7:0] w;
        n = (seed == 8'h00) ? 0 : ((burst < DEPTH) ? burst : DEPTH);
        w = seed;
        for (int i = 0; i < n; i++) begin
            exp_w[i] = w;
            w = lfsr_next(w);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (match_pulse || mismatch_pulse)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual match=%0b mismatch=%0b required=no pulse",
                         match_pulse, mismatch_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                $display("guess result: match=%0b mismatch=%0b score=%0d done=%0b",
                         match_pulse, mismatch_pulse, score, done);
                chk("guess_result", {25'd0, match_pulse, mismatch_pulse, score, done}, {25'd0, mon_e});
            end
        end
    end

    task automatic play_round(input logic [7:0] seed, input int burst, input bit gaps);
        int n, cnt, pos, k, guard;
        logic [3:0] ms;
        bit in_check;
        cur_seed  = seed;
        cur_burst = burst;
        gen_words(seed, burst, n);
        $display("round: seed=%02h burst=%0d guesses=%0d", seed, burst, g_q.size());
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("seed_lfsr_rst", lfsr_rst, 1);
        chk("seed_err_cleared", err, 0);
        chk("seed_score_cleared", score, 0);
        cnt = 0;
        @(negedge clk);
        while (lfsr_enable && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("capture_cycles", cnt, (seed == 8'h00) ? 1 : n);
        if (seed == 8'h00) begin
            chk("zero_done", done, 1);
            chk("zero_err", err, 1);
            chk("zero_score", score, 0);
            chk("zero_ready", guess_ready, 0);
            return;
        end
        in_check = 1'b1;
        ms = '0; pos = 0; k = 0; guard = 0;
        while (k < g_q.size() && guard < 200) begin
            guard++;
            chk("guess_ready", guess_ready, in_check);
            if (gaps && $urandom_range(0, 3) == 0) begin
                guess_valid = 1'b0;
            end else begin
                guess_valid = 1'b1;
                guess_data  = g_q[k];
                if (in_check) begin
                    if (g_q[k] == exp_w[pos]) begin
                        if (ms != 4'hF) ms++;
                        pos++;
                        if (pos == n) in_check = 1'b0;
                        exp_q.push_back({1'b1, 1'b0, ms, !in_check});
                    end else begin
                        in_check = 1'b0;
                        exp_q.push_back({1'b0, 1'b1, ms, 1'b1});
                    end
                end
                k++;
            end
            @(negedge clk);
        end
        guess_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pending_pulses", exp_q.size(), 0);
        chk("end_done", done, !in_check);
        chk("end_score", score, ms);
        chk("end_busy", busy, in_check);
        chk("end_err", err, 0);
    endtask

    task automatic load_correct(input logic [7:0] seed, input int burst);
        int n;
        gen_words(seed, burst, n);
        g_q.delete();
        for (int i = 0; i < n; i++) g_q.push_back(exp_w[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; guess_valid = 1'b0; guess_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_score", score, 0);
        chk("rst_outs", {lfsr_rst, lfsr_enable, guess_ready, match_pulse, mismatch_pulse}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full sequence, all matches
        load_correct(8'h01, 8);
        play_round(8'h01, 8, 1'b0);

        // Two matches then a mismatch; fourth guess must not be accepted
        g_q.delete();
        g_q.push_back(8'h01); g_q.push_back(8'h02); g_q.push_back(8'hFF); g_q.push_back(8'h04);
        play_round(8'h01, 8, 1'b0);

        // Zero seed, then restart from DONE
        g_q.delete();
        play_round(8'h00, 8, 1'b0);

        // guess_valid held through SEED/CAPTURE is ignored until CHECK
        load_correct(8'h01, 8);
        guess_valid = 1'b1; guess_data = 8'h01;
        play_round(8'h01, 8, 1'b0);

        // Early burst completion
        load_correct(8'h5A, 5);
        play_round(8'h5A, 5, 1'b1);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            logic [7:0] s;
            int b;
            s = 8'($urandom_range(1, 255));
            b = $urandom_range(1, 10);
            gen_words(s, b, n);
            g_q.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0) g_q.push_back(exp_w[i] ^ 8'($urandom_range(1, 255)));
                else g_q.push_back(exp_w[i]);
            end
            if ($urandom_range(0, 1) == 1) g_q.push_back(8'($urandom_range(0, 255)));
            play_round(s, b, 1'b1);
        end

        // Reset in the middle of CHECK after three matches
        g_q.delete();
        g_q.push_back(8'h01); g_q.push_back(8'h02); g_q.push_back(8'h04);
        play_round(8'h01, 8, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        $display("reset asserted mid-check");
        chk("midrst_score", score, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", guess_ready, 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_stays_idle", {busy, lfsr_rst, lfsr_enable, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
